// File: rtl/iobus_timer_intc_pkg.sv
// Shared definitions for the IO-bus timer / interrupt controller:
// register map offsets, control/status bit positions and FSM encoding.
package iobus_timer_intc_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'h1100_0100;

    localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
    localparam logic [31:0] OFF_PRESCALE = 32'h0000_0004;
    localparam logic [31:0] OFF_COUNT    = 32'h0000_0008;
    localparam logic [31:0] OFF_RELOAD   = 32'h0000_000C;
    localparam logic [31:0] OFF_STATUS   = 32'h0000_0010;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IE     = 2;
    localparam int STATUS_PEND = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tmr_state_t;

endpackage

// File: rtl/iobus_timer_intc_tick_gen.sv
// Prescaler: emits a one-cycle tick every prescale+1 cycles while enabled.
// The phase counter sits at 0 while disabled and is cleared on restart.
module tick_gen (
    input  logic        clk,
    input  logic        RESET,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] phase;

    // A restart cycle never ticks, so a reprogram always begins a fresh period.
    assign tick = en & ~restart & (phase == prescale);

    // Phase counter wraps to 0 on the tick cycle.
    always_ff @(posedge clk) begin
        if (RESET || restart || !en)
            phase <= 16'd0;
        else if (phase == prescale)
            phase <= 16'd0;
        else
            phase <= phase + 16'd1;
    end

endmodule

// File: rtl/iobus_timer_intc.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// level interrupt. Register block decoded on full 32-bit addresses at BASE.
module iobus_timer_intc
    import iobus_timer_intc_pkg::*;
#(
    parameter logic [31:0] BASE = DEFAULT_BASE
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    tmr_state_t  state;
    logic        auto_rl;
    logic        ie;
    logic [15:0] prescale;
    logic [31:0] count;
    logic [31:0] reload;
    logic        pend;

    logic hit_ctrl, hit_pre, hit_count, hit_reload, hit_status;
    logic wr_ctrl, wr_pre, wr_count, wr_reload, wr_status;
    logic en, tick, expire;
    logic pend_nxt, ie_nxt;

    assign hit_ctrl   = (IOBUS_ADDR == BASE + OFF_CTRL);
    assign hit_pre    = (IOBUS_ADDR == BASE + OFF_PRESCALE);
    assign hit_count  = (IOBUS_ADDR == BASE + OFF_COUNT);
    assign hit_reload = (IOBUS_ADDR == BASE + OFF_RELOAD);
    assign hit_status = (IOBUS_ADDR == BASE + OFF_STATUS);

    assign wr_ctrl   = IOBUS_WR & hit_ctrl;
    assign wr_pre    = IOBUS_WR & hit_pre;
    assign wr_count  = IOBUS_WR & hit_count;
    assign wr_reload = IOBUS_WR & hit_reload;
    assign wr_status = IOBUS_WR & hit_status;

    // EN is the FSM state itself, so the readback can never disagree with it.
    assign en = (state == ST_RUN);

    tick_gen u_tick_gen (
        .clk      (clk),
        .RESET    (RESET),
        .en       (en),
        .restart  (wr_ctrl | wr_pre),
        .prescale (prescale),
        .tick     (tick)
    );

    // A software COUNT write swallows the tick, so no expiry is evaluated then.
    assign expire = tick & ~wr_count & (count == 32'd0);

    // Next PEND / IE feed the registered INTR so it rises with PEND.
    always_comb begin
        pend_nxt = pend;
        if (wr_status && IOBUS_OUT[STATUS_PEND])
            pend_nxt = 1'b0;
        if (expire)
            pend_nxt = 1'b1;
        ie_nxt = wr_ctrl ? IOBUS_OUT[CTRL_IE] : ie;
    end

    // Register file, counter, FSM and interrupt output.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state    <= ST_IDLE;
            auto_rl  <= 1'b0;
            ie       <= 1'b0;
            prescale <= 16'd0;
            count    <= 32'd0;
            reload   <= 32'd0;
            pend     <= 1'b0;
            INTR     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (wr_ctrl && IOBUS_OUT[CTRL_EN]) state <= ST_RUN;
                ST_RUN: begin
                    if (wr_ctrl && !IOBUS_OUT[CTRL_EN])
                        state <= ST_IDLE;
                    else if (expire && !auto_rl)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (wr_ctrl) begin
                auto_rl <= IOBUS_OUT[CTRL_AUTO];
                ie      <= IOBUS_OUT[CTRL_IE];
            end
            if (wr_pre)
                prescale <= IOBUS_OUT[15:0];
            if (wr_reload)
                reload <= IOBUS_OUT;

            // Counter stops at 0 in one-shot mode; only a reload wraps it.
            if (wr_count)
                count <= IOBUS_OUT;
            else if (tick) begin
                if (count != 32'd0)
                    count <= count - 32'd1;
                else if (auto_rl)
                    count <= reload;
            end

            pend <= pend_nxt;
            INTR <= pend_nxt & ie_nxt;
        end
    end

    // Combinational read mux; unmapped addresses read 0.
    always_comb begin
        IOBUS_IN = 32'd0;
        if (hit_ctrl) begin
            IOBUS_IN[CTRL_EN]   = en;
            IOBUS_IN[CTRL_AUTO] = auto_rl;
            IOBUS_IN[CTRL_IE]   = ie;
        end else if (hit_pre)
            IOBUS_IN = {16'd0, prescale};
        else if (hit_count)
            IOBUS_IN = count;
        else if (hit_reload)
            IOBUS_IN = reload;
        else if (hit_status)
            IOBUS_IN[STATUS_PEND] = pend;
    end

endmodule

// File: doc/iobus_timer_intc.md
IOBUS_TIMER_INTC -- requirements
Module: iobus_timer_intc

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port IOBUS_ADDR, input, 32 bits: MCU IO address.
REQ-005 SHALL have port IOBUS_OUT, input, 32 bits: MCU write data.
REQ-006 SHALL have port IOBUS_WR, input, 1 bit: write strobe, one cycle per store.
REQ-007 SHALL have port IOBUS_IN, output, 32 bits: read data to MCU.
REQ-008 SHALL have port INTR, output, 1 bit: level interrupt request to MCU.
REQ-009 SHALL have parameter BASE, default 32'h1100_0100: base of the register block.

Function
REQ-010 SHALL decode full 32-bit addresses: CTRL=BASE+0x0, PRESCALE=+0x4, COUNT=+0x8, RELOAD=+0xC, STATUS=+0x10.
REQ-011 SHALL assign CTRL bits: [0] EN, [1] AUTO (auto-reload), [2] IE (interrupt enable); other bits read 0.
REQ-012 SHALL accept a write only when IOBUS_WR=1 and IOBUS_ADDR matches a mapped register; unmapped writes have no effect.
REQ-013 SHALL drive IOBUS_IN combinationally from IOBUS_ADDR and current register state; unmapped reads return 0.
REQ-014 SHALL implement PRESCALE as 16 bits (upper write bits ignored, read 0); tick asserts once every PRESCALE+1 clk cycles while EN=1; PRESCALE=0 gives a tick every cycle.
REQ-015 SHALL hold the prescaler at 0 while EN=0, and restart it at 0 on any write to CTRL or PRESCALE.
REQ-016 SHALL run FSM states IDLE (EN=0) and RUN (EN=1); CTRL write with EN=1 moves to RUN, EN=0 moves to IDLE.
REQ-017 SHALL, on a tick in RUN with COUNT!=0, decrement COUNT by 1.
REQ-018 SHALL, on a tick in RUN with COUNT==0, set PEND; COUNT loads RELOAD if AUTO=1, else EN clears and FSM goes to IDLE with COUNT held at 0.
REQ-019 SHALL give a software COUNT write priority over a same-cycle tick (tick discarded, no expiry evaluated).
REQ-020 SHALL make STATUS[0]=PEND read-only via hardware set, write-1-to-clear; writing 0 has no effect.
REQ-021 SHALL give a hardware PEND set priority over a same-cycle W1C.
REQ-022 SHALL drive INTR = PEND & IE, registered level, held until PEND cleared or IE cleared.
REQ-023 SHALL wrap COUNT arithmetic modulo 2^32 only through reload; no decrement below 0.

Reset
REQ-024 SHALL, on clk edge with RESET=1, clear CTRL, PRESCALE, COUNT, RELOAD, PEND, prescaler to 0 and FSM to IDLE; INTR=0 next cycle.
REQ-025 SHALL let RESET override any same-cycle write or tick, including mid-count.
REQ-026 SHALL show IOBUS_IN=0 for every mapped address after reset.

Structure
REQ-027 SHALL place register offsets, CTRL/STATUS bit positions and default BASE in a shared package.
REQ-028 SHALL implement the prescaler as one sub-module, tick_gen (inputs clk, RESET, en, restart, prescale; output tick).

Verification
REQ-029 SHALL cover: PRESCALE=0, RELOAD=3, COUNT=3, CTRL=0x7 -> PEND and INTR rise after 4 ticks (cycle 4 after CTRL write), COUNT=3 again, INTR repeats every 4 cycles until STATUS write 0x1.
REQ-030 SHALL cover: PRESCALE=9, COUNT=2, CTRL=0x5 (one-shot) -> expiry after 30 cycles, EN reads 0, COUNT stays 0, no further PEND after clear.
REQ-031 SHALL cover: COUNT write 0x100 in same cycle as a tick -> COUNT reads 0x100 next cycle, not 0xFF.
REQ-032 SHALL cover: STATUS W1C coincident with expiry -> PEND remains 1, INTR remains 1.
REQ-033 SHALL cover: RESET asserted mid-count (COUNT=0x50, EN=1) -> all reads 0, INTR=0 next cycle, no tick until reprogrammed.
REQ-034 SHALL cover: write 0xFFFF_FFFF to BASE+0x14 and read BASE+0x14 -> no register changes, IOBUS_IN=0.
